mbist_march_ctrl: RTL and testbench

- March C- MBIST engine sitting directly upstream of the fault-injectable memory model.
- Drives its write_read/address/wdata ports and checks its rdata against expected data.
- Reports pass/fail plus first-failure diagnostics: address, march element and captured data.
- One memory operation per clock, timed to the memory's 1-cycle write-data register and 2-cycle read pipeline.

---
 rtl/mbist_march_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
//
// March C- memory BIST engine. Drives one memory operation per clock and
// checks read data returned through the memory's 2-cycle read pipeline.
// The memory registers wdata one cycle before it uses it, so wdata is always
// driven one cycle ahead of the matching address/write_read.
//
// March sequence (Z = all zeros, O = all ones):
//   E0 up(w Z)  E1 up(r Z, w O)  E2 up(r O, w Z)
//   E3 dn(r Z, w O)  E4 dn(r O, w Z)  E5 up(r Z)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a test (honoured only in IDLE or DONE)
//   busy, done      run in progress / test finished (level)
//   fail            mismatch seen (valid with done)
//   fail_addr       address of the first mismatch
//   fail_element    march element (0..5) of the first mismatch
//   fail_data       read data captured at the first mismatch
//   write_read      to memory, 1 = write, 0 = read
//   address         to memory
//   wdata           to memory, leads address/write_read by one cycle
//   rdata           from memory, valid two cycles after the read
// ---------------------------------------------------------------------------
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZEROS      = '0;
  localparam logic [DATA_WIDTH-1:0] ONES       = '1;

  // E3 and E4 walk the address space downwards.
  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // E1..E4 carry a read followed by a write on each address.
  function automatic logic has_pair(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  // Phase 0 of a paired element is the read, phase 1 the write.
  function automatic logic is_write(input logic [2:0] e, input logic ph);
    return (e == 3'd0) ? 1'b1 : ((e == 3'd5) ? 1'b0 : ph);
  endfunction

  // Write data for writes, expected data for reads.
  function automatic logic [DATA_WIDTH-1:0] op_value(input logic [2:0] e, input logic ph);
    if (is_write(e, ph)) return ((e == 3'd1) || (e == 3'd3)) ? ONES : ZEROS;
    return ((e == 3'd2) || (e == 3'd4)) ? ONES : ZEROS;
  endfunction

  state_t                  state;
  logic [1:0]              drain_cnt;

  // Pointer to the op that will be placed on address/write_read next edge.
  logic [2:0]              elem;
  logic [ADDR_WIDTH-1:0]   ptr_addr;
  logic                    phase;

  logic [2:0]              nxt_elem;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    nxt_phase;
  logic                    last_op;
  logic [DATA_WIDTH-1:0]   nxt_wdata;

  // Read bookkeeping aligned with the op currently on the bus, then two
  // stages that follow the memory read pipeline.
  logic                    cur_valid;
  logic [DATA_WIDTH-1:0]   cur_exp;
  logic [2:0]              cur_elem;
  logic                    s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0]   s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0]   s1_addr, s2_addr;
  logic [2:0]              s1_elem, s2_elem;

  logic                    mismatch;

  assign mismatch = s2_valid && (rdata != s2_exp);

  // Successor of the pointed-to op; elements end exactly on their end
  // address, so the address counter never wraps.
  always_comb begin
    nxt_elem  = elem;
    nxt_addr  = ptr_addr;
    nxt_phase = 1'b0;
    last_op   = (elem == 3'd5) && (ptr_addr == LAST_ADDR);
    if (has_pair(elem) && !phase) begin
      nxt_phase = 1'b1;
    end else if (ptr_addr == (is_down(elem) ? FIRST_ADDR : LAST_ADDR)) begin
      nxt_elem = elem + 3'd1;
      nxt_addr = is_down(elem + 3'd1) ? LAST_ADDR : FIRST_ADDR;
    end else if (is_down(elem)) begin
      nxt_addr = ptr_addr - ADDR_ONE;
    end else begin
      nxt_addr = ptr_addr + ADDR_ONE;
    end
    // Reads carry no data; after the final op the bus returns to zero.
    nxt_wdata = (!last_op && is_write(nxt_elem, nxt_phase)) ?
                op_value(nxt_elem, nxt_phase) : ZEROS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      drain_cnt    <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_element <= 3'd0;
      fail_data    <= '0;
      write_read   <= 1'b0;
      address      <= '0;
      wdata        <= '0;
      elem         <= 3'd0;
      ptr_addr     <= '0;
      phase        <= 1'b0;
      cur_valid    <= 1'b0;
      cur_exp      <= '0;
      cur_elem     <= 3'd0;
      s1_valid     <= 1'b0;
      s1_exp       <= '0;
      s1_addr      <= '0;
      s1_elem      <= 3'd0;
      s2_valid     <= 1'b0;
      s2_exp       <= '0;
      s2_addr      <= '0;
      s2_elem      <= 3'd0;
    end else begin
      s1_valid <= cur_valid;
      s1_exp   <= cur_exp;
      s1_addr  <= address;
      s1_elem  <= cur_elem;
      s2_valid <= s1_valid;
      s2_exp   <= s1_exp;
      s2_addr  <= s1_addr;
      s2_elem  <= s1_elem;

      if (mismatch && !fail) begin
        fail         <= 1'b1;
        fail_addr    <= s2_addr;
        fail_element <= s2_elem;
        fail_data    <= rdata;
      end
      // After a mismatch the reads still in flight are meaningless.
      if (mismatch) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          write_read <= 1'b0;
          address    <= '0;
          wdata      <= '0;
          cur_valid  <= 1'b0;
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_element <= 3'd0;
            fail_data    <= '0;
            elem         <= 3'd0;
            ptr_addr     <= FIRST_ADDR;
            phase        <= 1'b0;
            // First RUN cycle only presents the data for op 0.
            wdata        <= op_value(3'd0, 1'b0);
          end
        end

        RUN: begin
          if (mismatch) begin
            // Stop issuing; two more cycles let the memory pipeline settle.
            state      <= DRAIN;
            drain_cnt  <= 2'd1;
            write_read <= 1'b0;
            address    <= '0;
            wdata      <= '0;
            cur_valid  <= 1'b0;
          end else begin
            write_read <= is_write(elem, phase);
            address    <= ptr_addr;
            wdata      <= nxt_wdata;
            cur_valid  <= !is_write(elem, phase);
            cur_exp    <= op_value(elem, phase);
            cur_elem   <= elem;
            elem       <= nxt_elem;
            ptr_addr   <= nxt_addr;
            phase      <= nxt_phase;
            if (last_op) begin
              state     <= DRAIN;
              drain_cnt <= 2'd0;
            end
          end
        end

        DRAIN: begin
          // Count 0 covers the cycle the final op is on the bus; counts 1
          // and 2 let its read return and be compared.
          write_read <= 1'b0;
          address    <= '0;
          wdata      <= '0;
          cur_valid  <= 1'b0;
          if (drain_cnt == 2'd2) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_ctrl
//
// Bench for mbist_march_ctrl with a behavioural memory (1-cycle write-data
// register, 2-cycle read pipeline, optional transition fault on bit 4 of
// address 5 blocking 1->0). A model derived from the march table predicts
// the op stream, the first mismatch and the status outputs every cycle.
// ---------------------------------------------------------------------------
module tb_mbist_march_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CAP = 15;
  localparam int N = CAP + 1;
  localparam int NOPS = 10 * N;
  localparam int FAULT_ADDR = 5;
  localparam int FAULT_BIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, fail, write_read;
  logic [AW-1:0] fail_addr, address;
  logic [2:0] fail_element;
  logic [DW-1:0] fail_data, wdata;
  logic [DW-1:0] rdata;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_element(fail_element),
    .fail_data(fail_data), .write_read(write_read), .address(address),
    .wdata(wdata), .rdata(rdata)
  );

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wreg, rd1;
  logic fault_en = 1'b0;

  function automatic logic [DW-1:0] faulty_write(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input int a, input logic en);
    logic [DW-1:0] r;
    r = new_v;
    if (en && a == FAULT_ADDR && old_v[FAULT_BIT]) r[FAULT_BIT] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    wreg  <= wdata;
    rd1   <= mem[address];
    rdata <= rd1;
    if (write_read) mem[address] <= faulty_write(mem[address], wreg, int'(address), fault_en);
  end

  // ---------------- march op table ----------------
  bit            op_wr   [NOPS];
  logic [AW-1:0] op_addr [NOPS];
  logic [2:0]    op_elem [NOPS];
  logic [DW-1:0] op_data [NOPS];

  task automatic build_table();
    int n;
    n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = (e == 3 || e == 4) ? CAP - i : i;
        if (e != 0) begin
          op_wr[n] = 1'b0; op_addr[n] = AW'(a); op_elem[n] = 3'(e);
          op_data[n] = (e == 2 || e == 4) ? {DW{1'b1}} : {DW{1'b0}};
          n++;
        end
        if (e != 5) begin
          op_wr[n] = 1'b1; op_addr[n] = AW'(a); op_elem[n] = 3'(e);
          op_data[n] = (e == 1 || e == 3) ? {DW{1'b1}} : {DW{1'b0}};
          n++;
        end
      end
    end
  endtask

  // ---------------- run model ----------------
  bit m_active = 1'b0;
  bit check_en = 1'b0;
  bit m_fault = 1'b0;
  int m_c = 0;
  int m_k = -1;
  int m_last_c = 0;
  int m_done_c = 0;
  logic [AW-1:0] m_faddr = '0;
  logic [2:0] m_felem = '0;
  logic [DW-1:0] m_fdata = '0;

  // Plays the march against a copy of the memory to find the first bad read.
  task automatic predict_run();
    logic [DW-1:0] arr [N];
    for (int a = 0; a < N; a++) arr[a] = mem[a];
    m_k = -1; m_faddr = '0; m_felem = '0; m_fdata = '0;
    for (int i = 0; i < NOPS; i++) begin
      int a;
      a = int'(op_addr[i]);
      if (op_wr[i]) arr[a] = faulty_write(arr[a], op_data[i], a, fault_en);
      else if (arr[a] !== op_data[i]) begin
        m_k = i; m_faddr = op_addr[i]; m_felem = op_elem[i]; m_fdata = arr[a];
        break;
      end
    end
  endtask

  // m_c = cycle number since the edge that accepted start (cycle 1 follows it).
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_c = 0;
      check_en = 1'b1;
    end else if (start && (!m_active || m_c >= m_done_c)) begin
      predict_run();
      m_fault = fault_en;
      m_active = 1'b1;
      m_c = 1;
      // Op k sits on the bus in cycle k+2; its compare lands in k+4, the
      // failure shows in k+5 and done follows two drain cycles later.
      m_last_c = (m_k >= 0 && m_k + 4 < NOPS + 1) ? m_k + 4 : NOPS + 1;
      m_done_c = (m_k >= 0 && m_k + 7 < NOPS + 4) ? m_k + 7 : NOPS + 4;
    end else if (m_active) begin
      m_c++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t, cycle %0d)", name, act, exp, $time, m_c);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_busy, e_done, e_fail, e_wr;
    logic [AW-1:0] e_addr, e_faddr;
    logic [2:0] e_felem;
    logic [DW-1:0] e_wdata, e_fdata;
    if (check_en) begin
      e_busy = 1'b0; e_done = 1'b0; e_fail = 1'b0; e_wr = 1'b0;
      e_addr = '0; e_faddr = '0; e_felem = '0; e_wdata = '0; e_fdata = '0;
      if (m_active) begin
        e_done = (m_c >= m_done_c);
        e_busy = !e_done;
        if (m_c >= 2 && m_c <= m_last_c) begin
          e_wr = op_wr[m_c - 2];
          e_addr = op_addr[m_c - 2];
        end
        if (m_c >= 1 && m_c <= m_last_c && (m_c - 1) < NOPS) begin
          if (op_wr[m_c - 1]) e_wdata = op_data[m_c - 1];
        end
        if (m_k >= 0 && m_c >= m_k + 5) begin
          e_fail = 1'b1; e_faddr = m_faddr; e_felem = m_felem; e_fdata = m_fdata;
        end
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("fail", 32'(fail), 32'(e_fail));
      chk("fail_addr", 32'(fail_addr), 32'(e_faddr));
      chk("fail_element", 32'(fail_element), 32'(e_felem));
      chk("fail_data", 32'(fail_data), 32'(e_fdata));
      chk("write_read", 32'(write_read), 32'(e_wr));
      chk("address", 32'(address), 32'(e_addr));
      chk("wdata", 32'(wdata), 32'(e_wdata));

      // Hand-computed anchors for the model itself.
      if (m_active) begin
        if (m_c == 1) begin
          chk("lit_c1_wdata", 32'(wdata), 32'h00);
          chk("lit_c1_busy", 32'(busy), 32'h1);
          if (m_fault) chk("lit_model_fail_op", 32'(m_k), 32'd100);
        end
        if (m_c == 2) begin
          chk("lit_c2_wr", 32'(write_read), 32'h1);
          chk("lit_c2_addr", 32'(address), 32'h0);
        end
        if (m_c == 82) begin
          chk("lit_e3_first_wr", 32'(write_read), 32'h0);
          chk("lit_e3_first_addr", 32'(address), 32'd15);
        end
        if (m_c == 83) begin
          chk("lit_e3_second_wr", 32'(write_read), 32'h1);
          chk("lit_e3_second_addr", 32'(address), 32'd15);
        end
        if (m_k < 0 && m_c == 161) begin
          chk("lit_last_op_wr", 32'(write_read), 32'h0);
          chk("lit_last_op_addr", 32'(address), 32'd15);
        end
        if (m_k < 0 && m_c == 163) begin
          chk("lit_c163_busy", 32'(busy), 32'h1);
          chk("lit_c163_done", 32'(done), 32'h0);
        end
        if (m_k < 0 && m_c == 164) begin
          chk("lit_c164_done", 32'(done), 32'h1);
          chk("lit_c164_busy", 32'(busy), 32'h0);
          chk("lit_c164_fail", 32'(fail), 32'h0);
        end
        if (m_fault && m_c == 107) begin
          chk("lit_fault_done", 32'(done), 32'h1);
          chk("lit_fault_fail", 32'(fail), 32'h1);
          chk("lit_fault_addr", 32'(fail_addr), 32'd5);
          chk("lit_fault_elem", 32'(fail_element), 32'd3);
          chk("lit_fault_data", 32'(fail_data), 32'h10);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_timeout"}, 32'(seen), 32'h1);
    $display("run %s: done at cycle %0d fail=%0b fail_addr=%0d fail_element=%0d fail_data=%02h",
             name, m_c, fail, fail_addr, fail_element, fail_data);
  endtask

  initial begin
    build_table();
    for (int a = 0; a < N; a++) mem[a] = '0;
    wreg = '0; rd1 = '0; rdata = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fault-free full run.
    pulse_start();
    wait_done("fault_free", 300);

    // Transition fault run, restarted from DONE.
    fault_en = 1'b1;
    pulse_start();
    wait_done("transition_fault", 300);

    // Fault-free run with start held, interrupted by reset at cycle 50.
    fault_en = 1'b0;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100 && m_c < 50; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("run reset_mid_run: reset applied, busy=%0b done=%0b", busy, done);
    repeat (3) @(posedge clk);
    #1;
    pulse_start();
    wait_done("after_reset", 300);

    // Failing run with start held high, then a clean restart from DONE.
    fault_en = 1'b1;
    start = 1'b1;
    repeat (30) @(posedge clk);
    #1 start = 1'b0;
    wait_done("held_start_fault", 300);
    fault_en = 1'b0;
    pulse_start();
    wait_done("restart_clean", 300);
    chk("restart_final_fail", 32'(fail), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
